// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared types and constants for the rv32i instruction-fetch front end.
//   fetch_state_t : fetch FSM state encoding
//   NOP_INST      : value shown on inst out of reset (addi x0,x0,0)
//   DEF_RESET_PC  : default reset PC
//   pc_aligned()  : true when a PC is 4-byte aligned
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end of the non-pipelined rv32i core. Holds the PC,
// issues one imem read per instruction, hands the word to decode, then waits
// for execute to return the next PC.
// Ports:
//   clk, rst              : core clock; asynchronous active-low reset
//   next_pc_valid/next_pc : next PC pulse from execute
//   imem_req_*/imem_addr  : read request to instruction memory (valid/ready)
//   imem_rsp_*            : read response from instruction memory
//   inst_valid/ready      : handshake to decode, with inst and inst_pc
//   fault                 : sticky, set on misaligned next_pc
//   fetch_count           : instructions handed to decode (wraps)
// All outputs come straight from registers; no input-to-output paths.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_inst, r_inst_pc, r_fetch_count;
    logic         w_capture, w_consume;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (imem_req_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    w_consume = 1'b1;
                    // Execute can resolve the next PC in the consume cycle;
                    // taking it here skips NEXT and gives the 3-cycle loop.
                    if (next_pc_valid) begin
                        if (pc_aligned(next_pc)) begin
                            w_pc_nxt    = next_pc;
                            w_state_nxt = ST_REQ;
                        end else begin
                            w_state_nxt = ST_FAULT;
                        end
                    end else begin
                        w_state_nxt = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (next_pc_valid) begin
                    if (pc_aligned(next_pc)) begin
                        w_pc_nxt    = next_pc;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_inst        <= NOP_INST;
            r_inst_pc     <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_inst    <= imem_rsp_data;
                r_inst_pc <= r_pc;
            end
            if (w_consume) r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_addr      = r_pc;
    assign inst_valid     = (r_state == ST_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign fault          = (r_state == ST_FAULT);
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Transaction-level bench: the model tracks only the architectural PC, the
// instruction count and the fault flag; the memory is a pure function of the
// address. Each fetch is driven with randomized stalls and junk on inputs
// that must be ignored in the current phase.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        next_pc_valid = 1'b0;
    logic [31:0] next_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc_valid  (next_pc_valid),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        next_pc_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b0;
        #1;
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        chk("rst_req_valid", 32'(imem_req_valid), 1);
        chk("rst_addr",      imem_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_fault",     32'(fault), 0);
        chk("rst_count",     fetch_count, 32'h0);
        step();
        step();
        rst = 1'b1;
    endtask

    // One full fetch. Entered #1 after an edge with the DUT expected in REQ.
    task automatic do_fetch(input int rq_stall, input int rsp_lat, input int dec_stall,
                            input bit same_cycle, input int np_lat,
                            input logic [31:0] npc, input int exp_period, input bit wrap);
        int t0;
        t0 = cyc;
        chk("req_valid", 32'(imem_req_valid), 1);
        chk("req_addr",  imem_addr, m_pc);
        imem_req_ready = 1'b0;
        for (int i = 0; i < rq_stall; i++) begin
            // stale/junk response while requesting must be dropped
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            step();
            chk("req_hold_valid", 32'(imem_req_valid), 1);
            chk("req_hold_addr",  imem_addr, m_pc);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", 32'(imem_req_valid), 0);
        chk("wait_inst_valid", 32'(inst_valid), 0);
        for (int i = 0; i < rsp_lat; i++) begin
            next_pc_valid = 1'($urandom_range(0, 1));
            next_pc = $urandom;
            step();
            chk("wait_stay", 32'({imem_req_valid, inst_valid}), 0);
        end
        next_pc_valid  = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m_pc);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        chk("hold_inst_valid", 32'(inst_valid), 1);
        chk("hold_inst",       inst, mem_word(m_pc));
        chk("hold_inst_pc",    inst_pc, m_pc);
        for (int i = 0; i < dec_stall; i++) begin
            next_pc_valid = 1'($urandom_range(0, 1));
            next_pc = $urandom;
            step();
            chk("stall_inst",  inst, mem_word(m_pc));
            chk("stall_valid", 32'(inst_valid), 1);
            chk("stall_count", fetch_count, m_cnt);
        end
        next_pc_valid = 1'b0;
        if (wrap) begin
            force dut.r_fetch_count = 32'hFFFF_FFFF;
            #2;
            release dut.r_fetch_count;
            m_cnt = 32'hFFFF_FFFF;
        end
        inst_ready = 1'b1;
        if (same_cycle) begin
            next_pc_valid = 1'b1;
            next_pc = npc;
        end
        step();
        inst_ready = 1'b0;
        next_pc_valid = 1'b0;
        m_cnt = m_cnt + 32'd1;
        chk("count", fetch_count, m_cnt);
        chk("consumed_inst_valid", 32'(inst_valid), 0);
        if (!same_cycle) begin
            for (int i = 0; i < np_lat; i++) begin
                imem_rsp_valid = 1'($urandom_range(0, 1));
                imem_rsp_data  = $urandom;
                step();
                chk("next_idle", 32'({imem_req_valid, inst_valid, fault}), 0);
            end
            imem_rsp_valid = 1'b0;
            next_pc_valid = 1'b1;
            next_pc = npc;
            step();
            next_pc_valid = 1'b0;
        end
        if (npc[1:0] != 2'b00) begin
            chk("fault_set", 32'({fault, imem_req_valid, inst_valid}), 32'b100);
        end else begin
            m_pc = npc;
            chk("no_fault", 32'(fault), 0);
        end
        if (exp_period != 0) chk("period", 32'(cyc - t0), 32'(exp_period));
    endtask

    initial begin
        do_reset();
        // best case: accept, respond, consume + next_pc together -> 3 cycles
        do_fetch(0, 0, 0, 1'b1, 0, 32'h40, 3, 1'b0);
        // request stall 4, decode stall 3, next_pc via NEXT
        do_fetch(4, 2, 3, 1'b0, 2, 32'h0000_1000, 0, 1'b0);
        for (int k = 0; k < 25; k++) begin
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom & 32'hFFFF_FFFC, 0, 1'b0);
        end
        // counter wraps
        do_fetch(1, 1, 1, 1'b1, 0, 32'h80, 0, 1'b1);

        // reset in WAIT; the abandoned response lands in REQ and is dropped
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
        m_pc = 32'h0;
        m_cnt = 32'h0;
        chk("midrst_req_valid", 32'(imem_req_valid), 1);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_count", fetch_count, 32'h0);
        #2;
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("stale_drop", 32'({imem_req_valid, inst_valid}), 32'b10);
        do_fetch(0, 1, 0, 1'b1, 0, 32'h40, 0, 1'b0);

        // misaligned next_pc -> sticky fault
        do_fetch(0, 0, 0, 1'b0, 1, 32'h42, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            inst_ready     = 1'($urandom_range(0, 1));
            next_pc_valid  = 1'($urandom_range(0, 1));
            next_pc        = $urandom & 32'hFFFF_FFFC;
            step();
            chk("fault_sticky", 32'({fault, imem_req_valid, inst_valid}), 32'b100);
        end
        do_reset();
        do_fetch(0, 0, 0, 1'b1, 0, 32'h8, 0, 1'b0);
        // misaligned in the consume cycle
        do_fetch(0, 0, 0, 1'b1, 0, 32'h9, 0, 1'b0);
        chk("fault_count", fetch_count, m_cnt);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
